monitor_cmd_deframer: RTL and testbench

//  Upstream feeder of the monitor command FIFO. Takes raw bytes from the host UART receiver and hunts
//  for a sync byte. It assembles 4 payload bytes into one 32-bit command and checks an XOR checksum.

---
 rtl/monitor_cmd_deframer.sv | 147 ++++++++++++++
 tb/tb_monitor_cmd_deframer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_cmd_deframer.sv
// -----------------------------------------------------------------------------
// monitor_cmd_deframer
//
// Upstream feeder of the monitor command FIFO. Hunts the host UART byte stream
// for SYNC_BYTE, assembles the following four payload bytes into a big-endian
// 32-bit command, verifies the trailing XOR checksum and pushes good commands
// into the input FIFO. Bad checksums, inter-byte timeouts and bytes arriving
// while a command waits on a full FIFO are tallied in saturating counters.
//
// Frame (wire order): SYNC_BYTE, B0, B1, B2, B3, CHK   with CHK = B0^B1^B2^B3
//
// Ports
//   clk              in   1   system clock, posedge
//   rst              in   1   asynchronous active-high reset
//   rx_data          in   8   received byte, qualified by rx_valid
//   rx_valid         in   1   one byte per high cycle
//   fifo_data        out  32  assembled command {B0,B1,B2,B3}
//   fifo_wr          out  1   FIFO write strobe, one cycle per command
//   fifo_full        in   1   FIFO full, blocks fifo_wr
//   busy             out  1   high whenever a frame is in progress
//   err_checksum_cnt out  8   frames dropped on checksum mismatch (saturating)
//   err_timeout_cnt  out  8   frames aborted by inter-byte timeout (saturating)
//   err_overflow_cnt out  8   bytes dropped while waiting on full FIFO (saturating)
// -----------------------------------------------------------------------------
module monitor_cmd_deframer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter int         TMO_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] fifo_data,
    output logic        fifo_wr,
    input  logic        fifo_full,
    output logic        busy,
    output logic [7:0]  err_checksum_cnt,
    output logic [7:0]  err_timeout_cnt,
    output logic [7:0]  err_overflow_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        PUSH    = 2'd3
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [1:0]       byte_idx;
    logic [7:0]       chk;
    logic [TMO_W-1:0] tmo;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // Write strobe is decoded straight from state so the FIFO sees it in the
    // same cycle fifo_full drops.
    assign fifo_wr = (state == PUSH) && !fifo_full;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            byte_idx         <= 2'd0;
            chk              <= 8'd0;
            tmo              <= '0;
            fifo_data        <= 32'd0;
            err_checksum_cnt <= 8'd0;
            err_timeout_cnt  <= 8'd0;
            err_overflow_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Non-sync bytes are silently ignored while hunting.
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state    <= PAYLOAD;
                        byte_idx <= 2'd0;
                        chk      <= 8'd0;
                        tmo      <= '0;
                    end
                end

                PAYLOAD: begin
                    if (rx_valid) begin
                        // SYNC_BYTE inside the payload is ordinary data.
                        case (byte_idx)
                            2'd0:    fifo_data[31:24] <= rx_data;
                            2'd1:    fifo_data[23:16] <= rx_data;
                            2'd2:    fifo_data[15:8]  <= rx_data;
                            default: fifo_data[7:0]   <= rx_data;
                        endcase
                        chk      <= chk ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        tmo      <= '0;
                        if (byte_idx == 2'd3) begin
                            state <= CHECK;
                        end
                    end else if (tmo == TMO_LAST) begin
                        state           <= IDLE;
                        tmo             <= '0;
                        err_timeout_cnt <= sat_inc(err_timeout_cnt);
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end

                CHECK: begin
                    if (rx_valid) begin
                        tmo <= '0;
                        // A mismatching byte is consumed here, never re-hunted as sync.
                        if (rx_data == chk) begin
                            state <= PUSH;
                        end else begin
                            state            <= IDLE;
                            err_checksum_cnt <= sat_inc(err_checksum_cnt);
                        end
                    end else if (tmo == TMO_LAST) begin
                        state           <= IDLE;
                        tmo             <= '0;
                        err_timeout_cnt <= sat_inc(err_timeout_cnt);
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end

                PUSH: begin
                    // Only one command is buffered; any byte arriving now is lost,
                    // including on the cycle the write finally goes out.
                    if (rx_valid) begin
                        err_overflow_cnt <= sat_inc(err_overflow_cnt);
                    end
                    if (!fifo_full) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_monitor_cmd_deframer.sv
// -----------------------------------------------------------------------------
// tb_monitor_cmd_deframer
//
// Scenario tasks driving monitor_cmd_deframer one clock at a time. A frame-level
// reference model (byte queue, idle counter, pending-command flag) tracks what
// the deframer should be doing; per-cycle disagreements are tallied and each
// scenario then checks those tallies plus scenario-specific expectations.
// -----------------------------------------------------------------------------
module tb_monitor_cmd_deframer;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] fifo_data;
    logic        fifo_wr;
    logic        fifo_full;
    logic        busy;
    logic [7:0]  err_checksum_cnt;
    logic [7:0]  err_timeout_cnt;
    logic [7:0]  err_overflow_cnt;

    always #5 clk = ~clk;

    monitor_cmd_deframer #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO),
        .TMO_W          (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .fifo_data        (fifo_data),
        .fifo_wr          (fifo_wr),
        .fifo_full        (fifo_full),
        .busy             (busy),
        .err_checksum_cnt (err_checksum_cnt),
        .err_timeout_cnt  (err_timeout_cnt),
        .err_overflow_cnt (err_overflow_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_hunting;
    bit          m_pending;
    logic [7:0]  m_fr[$];
    int          m_idle;
    logic [31:0] m_word;
    int          m_ck, m_to, m_ov, m_writes;

    // Per-cycle observation tallies
    int          timing_bad = 0;
    int          data_bad   = 0;
    int          cnt_bad    = 0;
    int          wr_count   = 0;
    logic [31:0] last_data  = 32'd0;
    logic        obs_wr;

    function automatic int sat(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    function automatic bit rand_full();
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic model_reset();
        m_hunting = 1'b1;
        m_pending = 1'b0;
        m_fr.delete();
        m_idle    = 0;
        m_word    = 32'd0;
        m_ck      = 0;
        m_to      = 0;
        m_ov      = 0;
    endtask

    // One clock: drive inputs, observe at negedge, advance the model at posedge.
    task automatic step(input bit v, input logic [7:0] d, input bit f);
        logic [7:0] x;
        rx_valid  = v;
        rx_data   = d;
        fifo_full = f;
        @(negedge clk);
        obs_wr = fifo_wr;
        if (fifo_wr !== (m_pending && !f)) timing_bad++;
        if (busy !== !m_hunting) timing_bad++;
        if (fifo_wr === 1'b1) begin
            wr_count++;
            last_data = fifo_data;
        end
        if (m_pending && fifo_data !== m_word) data_bad++;
        if (int'(err_checksum_cnt) != m_ck || int'(err_timeout_cnt) != m_to ||
            int'(err_overflow_cnt) != m_ov) cnt_bad++;

        if (m_pending) begin
            if (v) m_ov = sat(m_ov);
            if (!f) begin
                m_pending = 1'b0;
                m_hunting = 1'b1;
                m_writes++;
            end
        end else if (m_hunting) begin
            if (v && d == SYNC) begin
                m_hunting = 1'b0;
                m_fr.delete();
                m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            m_fr.push_back(d);
            if (m_fr.size() == 5) begin
                x = m_fr[0] ^ m_fr[1] ^ m_fr[2] ^ m_fr[3];
                if (x == m_fr[4]) begin
                    m_pending = 1'b1;
                    m_word    = {m_fr[0], m_fr[1], m_fr[2], m_fr[3]};
                end else begin
                    m_ck      = sat(m_ck);
                    m_hunting = 1'b1;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                m_to      = sat(m_to);
                m_hunting = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input logic [31:0] w, input logic [7:0] c);
        send(SYNC);
        send(w[31:24]);
        send(w[23:16]);
        send(w[15:8]);
        send(w[7:0]);
        send(c);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b fifo_wr=%b, required 0/0", busy, fifo_wr);
        end
        checks++;
        if (fifo_data !== 32'd0 || err_checksum_cnt !== 8'd0 ||
            err_timeout_cnt !== 8'd0 || err_overflow_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_data: data=%h ck=%0d to=%0d ov=%0d, required all 0",
                     fifo_data, err_checksum_cnt, err_timeout_cnt, err_overflow_cnt);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        int w0 = wr_count;
        send(8'h00); send(8'hFF); send(SYNC);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h08);
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (obs_wr !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency: fifo_wr=%b one cycle after CHK, required 1", obs_wr);
        end
        idle(3);
        checks++;
        if (wr_count - w0 != 1 || last_data !== 32'h12345678) begin
            failures++;
            $display("FAIL basic_write: writes=%0d data=%h, required 1 / 12345678",
                     wr_count - w0, last_data);
        end
        checks++;
        if (err_checksum_cnt !== 8'd0 || err_timeout_cnt !== 8'd0 || err_overflow_cnt !== 8'd0) begin
            failures++;
            $display("FAIL basic_errs: ck=%0d to=%0d ov=%0d, required 0",
                     err_checksum_cnt, err_timeout_cnt, err_overflow_cnt);
        end
    endtask

    task automatic test_checksum();
        int w0 = wr_count;
        send_frame(32'h12345678, 8'h09);
        idle(2);
        checks++;
        if (wr_count != w0 || err_checksum_cnt !== 8'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL checksum_bad: writes=%0d ck=%0d busy=%b, required 0 / 1 / 0",
                     wr_count - w0, err_checksum_cnt, busy);
        end
        send_frame(32'hDEADBEEF, 8'h22);
        idle(2);
        checks++;
        if (wr_count - w0 != 1 || last_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL checksum_good: writes=%0d data=%h, required 1 / deadbeef",
                     wr_count - w0, last_data);
        end
    endtask

    task automatic test_timeout();
        int w0 = wr_count;
        send(SYNC); send(8'h12); send(8'h34);
        idle(TMO);
        checks++;
        if (err_timeout_cnt !== 8'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort: to=%0d busy=%b, required 1 / 0", err_timeout_cnt, busy);
        end
        send(SYNC); send(8'h12); send(8'h34);
        idle(TMO - 1);
        send(8'h56); send(8'h78); send(8'h08);
        idle(2);
        checks++;
        if (err_timeout_cnt !== 8'd1 || wr_count - w0 != 1 || last_data !== 32'h12345678) begin
            failures++;
            $display("FAIL timeout_edge: to=%0d writes=%0d data=%h, required 1 / 1 / 12345678",
                     err_timeout_cnt, wr_count - w0, last_data);
        end
    endtask

    task automatic test_full();
        int w0 = wr_count;
        logic [31:0] held;
        step(1'b1, SYNC, 1'b1);
        step(1'b1, 8'hCA, 1'b1);
        step(1'b1, 8'hFE, 1'b1);
        step(1'b1, 8'hBA, 1'b1);
        step(1'b1, 8'hBE, 1'b1);
        step(1'b1, 8'hCA ^ 8'hFE ^ 8'hBA ^ 8'hBE, 1'b1);
        held = fifo_data;
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
        checks++;
        if (wr_count != w0 || fifo_data !== held || held !== 32'hCAFEBABE || busy !== 1'b1) begin
            failures++;
            $display("FAIL full_hold: writes=%0d data=%h busy=%b, required 0 / cafebabe / 1",
                     wr_count - w0, fifo_data, busy);
        end
        step(1'b1, SYNC, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (err_overflow_cnt !== 8'd1) begin
            failures++;
            $display("FAIL full_overflow: ov=%0d, required 1", err_overflow_cnt);
        end
        checks++;
        if (obs_wr !== 1'b1 || last_data !== 32'hCAFEBABE) begin
            failures++;
            $display("FAIL full_release: fifo_wr=%b data=%h, required 1 / cafebabe", obs_wr, last_data);
        end
        idle(2);
        checks++;
        if (wr_count - w0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_single: writes=%0d busy=%b, required 1 / 0", wr_count - w0, busy);
        end
    endtask

    task automatic test_async_reset();
        int w0;
        send(SYNC); send(8'h12); send(8'h34);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || err_checksum_cnt !== 8'd0 || err_timeout_cnt !== 8'd0 ||
            err_overflow_cnt !== 8'd0 || fifo_wr !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%b ck=%0d to=%0d ov=%0d wr=%b, required all 0",
                     busy, err_checksum_cnt, err_timeout_cnt, err_overflow_cnt, fifo_wr);
        end
        #1 rst = 1'b0;
        model_reset();
        w0 = wr_count;
        send(8'h56);
        send_frame(32'h0BADF00D, 8'h0B ^ 8'hAD ^ 8'hF0 ^ 8'h0D);
        idle(2);
        checks++;
        if (wr_count - w0 != 1 || last_data !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL async_recover: writes=%0d data=%h, required 1 / 0badf00d",
                     wr_count - w0, last_data);
        end
    endtask

    task automatic test_saturation();
        int w0 = wr_count;
        logic [31:0] w;
        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            send_frame(w, w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0] ^ 8'h01);
        end
        idle(2);
        checks++;
        if (err_checksum_cnt !== 8'd255 || wr_count != w0) begin
            failures++;
            $display("FAIL saturation: ck=%0d writes=%0d, required 255 / 0",
                     err_checksum_cnt, wr_count - w0);
        end
    endtask

    task automatic rand_byte(input logic [7:0] b);
        if ($urandom_range(0, 7) == 0) begin
            int n = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), rand_full());
        end
        step(1'b1, b, rand_full());
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [7:0]  c;
        int          w0;
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        m_writes = 0;
        w0 = wr_count;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) rand_byte(8'($urandom));
            w = $urandom;
            if ($urandom_range(0, 1) == 0) w[15:8] = SYNC;
            c = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            if ($urandom_range(0, 3) == 0) c = c ^ 8'h5A;
            rand_byte(SYNC);
            rand_byte(w[31:24]);
            rand_byte(w[23:16]);
            rand_byte(w[15:8]);
            rand_byte(w[7:0]);
            rand_byte(c);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0);
        checks++;
        if (timing_bad != 0 || data_bad != 0) begin
            failures++;
            $display("FAIL random_cycle: timing_bad=%0d data_bad=%0d, required 0 / 0",
                     timing_bad, data_bad);
        end
        checks++;
        if (cnt_bad != 0) begin
            failures++;
            $display("FAIL random_counters: cnt_bad=%0d, required 0", cnt_bad);
        end
        checks++;
        if (wr_count - w0 != m_writes || m_writes == 0) begin
            failures++;
            $display("FAIL random_writes: writes=%0d, required %0d (nonzero)",
                     wr_count - w0, m_writes);
        end
    endtask

    initial begin
        m_writes = 0;
        test_reset();
        test_basic();
        test_checksum();
        test_timeout();
        test_full();
        test_async_reset();
        test_saturation();
        checks++;
        if (timing_bad != 0 || data_bad != 0 || cnt_bad != 0) begin
            failures++;
            $display("FAIL directed_cycles: timing_bad=%0d data_bad=%0d cnt_bad=%0d, required 0",
                     timing_bad, data_bad, cnt_bad);
        end
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
